button_press_tx: RTL and testbench
==================================

# button_press_tx

Debounces the board push-button and, on each press, transmits the running press count over UART as an ASCII message. Sits directly downstream of the 100 MHz rPLL and runs entirely on its output clock. It is the first consumer of the PLL clock and drives the board UART TX pin.

## Interface
- CLK_HZ, 100_000_000: frequency of clk in Hz.
- BAUD, 115200: UART bit rate. Derived BAUD_DIV = (CLK_HZ + BAUD/2) / BAUD, which is 868 at the defaults.
- DEBOUNCE_CYCLES, 1_000_000: number of consecutive stable synchronized samples required to accept a button level change (10 ms at the default clock).
- clk, input, 1: 100 MHz clock from the PLL clkout.
- rst, input, 1: synchronous, active-high reset.
- button_n, input, 1: raw asynchronous push-button, active low.
- uart_tx, output, 1: serial line, idles high, 8N1, LSB first.
- busy, output, 1: high while a message is in flight or pending.
- press_count, output, 8: number of accepted presses, wrapping modulo 256.

## Operation
- **Input conditioning**
  - button_n passes through a 2-FF synchronizer, then is inverted to give pressed = 1.
  - The debouncer holds a stable state (reset value: released) and a counter.
  - The counter clears whenever the synchronized sample equals the stable state.
  - When the sample differs for DEBOUNCE_CYCLES consecutive cycles, the stable state flips.
  - A released→pressed flip generates a one-cycle press pulse. Release flips generate nothing.
- **Counting**
  - Each press pulse increments press_count, wrapping 0xFF→0x00.
  - Counting is independent of UART activity; presses are never ignored by the counter.
- **Message**: four bytes, sent back-to-back.
  - Byte 0: ASCII hex of the upper nibble of the snapshot.
  - Byte 1: ASCII hex of the lower nibble, uppercase ('0'-'9', 'A'-'F').
  - Byte 2: CR (0x0D). Byte 3: LF (0x0A).
  - The snapshot is press_count after the increment, captured in the cycle the message starts.
- **Message FSM**: IDLE, SEND.
  - IDLE→SEND on a press pulse, or when the pending flag is set.
  - In SEND, the byte index steps 0..3. After the stop bit of byte 3: go to SEND (restart) if pending is set, otherwise IDLE.
- **Pending**
  - A press pulse while in SEND sets a single pending flag. Further presses during SEND only increment the count.
  - Pending clears when the next message starts. That message uses the count as it is at that moment.
- **Frame**: start bit (0), then 8 data bits LSB first, then stop bit (1). Each bit lasts exactly BAUD_DIV cycles.
- **Outputs**: busy = (state == SEND) or pending.
- **Reset values**: uart_tx = 1, busy = 0, press_count = 0, state = IDLE, pending = 0, debounced state = released, synchronizer flops = 1 (not pressed).
- **Reset mid-frame**: uart_tx returns high on the reset edge. The partial frame is abandoned, never resumed.

## Timing
- Latency from button to line:
  - button_n low is first sampled at edge E.
  - The press pulse is high in the cycle after edge E + 2 + DEBOUNCE_CYCLES.
  - uart_tx falls at the next edge. press_count updates on that same edge.
- uart_tx is a registered output; it never glitches between bits.
- Message duration is exactly 40 × BAUD_DIV cycles, with no idle gap between bytes.
- With pending set, the next start bit follows the last stop bit with no gap.
- A press pulse in the same cycle as the final stop-bit cycle sets pending; the message restarts immediately.
- Any bounce shorter than DEBOUNCE_CYCLES produces no pulse. A bounce of exactly DEBOUNCE_CYCLES − 1 cycles is rejected.

## Structure
- Package button_uart_pkg holds:
  - ASCII_CR and ASCII_LF constants.
  - MSG_BYTES = 4.
  - The nibble-to-ASCII-hex function.
  - The FSM state enum.
- Sub-module uart_tx_byte: a byte serializer with a valid/ready handshake (parameter BAUD_DIV, ports clk, rst, data[7:0], valid, ready, tx). It owns the baud counter and the bit index.
- The top level holds the synchronizer, debouncer, counter, pending flag and message FSM.

## Test plan
All scenarios use CLK_HZ/BAUD such that BAUD_DIV = 4, and DEBOUNCE_CYCLES = 8.

- **Single press**: hold button_n low for 50 cycles from reset.
  - press_count = 0x01.
  - uart_tx carries 0x30, 0x31, 0x0D, 0x0A over exactly 160 cycles.
  - busy falls at the end of the last stop bit.
- **Bounce rejection**: pulse button_n low for 7 cycles, then high.
  - No press pulse, press_count stays 0x00, uart_tx stays high.
  - An 8-cycle low pulse then yields count 0x01.
- **Press during message**: press, then press twice more during the first message.
  - press_count = 0x03.
  - Second message "03\r\n" starts with no idle gap; no third message follows.
- **Wrap-around**: 256 presses, separated by long gaps.
  - press_count reaches 0x00.
  - Last message is "00\r\n"; message 255 is "FF\r\n".
- **Reset mid-frame**: assert rst during bit 3 of byte 1.
  - On the next edge: uart_tx = 1, busy = 0, press_count = 0x00.
  - No further line activity until a new press.
- **Release ignored**: release after a stable press.
  - No message, press_count unchanged.

Source files
------------

// File: rtl/button_uart_pkg.sv
// ============================================================================
// Module   : button_uart_pkg
// Purpose  : Shared constants, message FSM state type and hex helper for
//            the push-button UART reporter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package button_uart_pkg;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam int         MSG_BYTES = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } msg_state_t;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ============================================================================
// Module   : uart_tx_byte
// Purpose  : 8N1 byte serializer with valid/ready handshake, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_byte #(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int             CNT_W       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] C_BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]     C_LAST_DATA = 4'd8;
  localparam logic [3:0]     C_STOP_IDX  = 4'd9;

  logic             r_busy;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [3:0]       r_bit_idx;
  logic [7:0]       r_data;
  logic             r_tx;

  logic w_bit_end;
  logic w_frame_end;

  assign w_bit_end   = r_busy && (r_baud_cnt == C_BAUD_LAST);
  assign w_frame_end = w_bit_end && (r_bit_idx == C_STOP_IDX);

  // Ready in the final stop-bit cycle lets the next start bit follow with no gap.
  assign ready = ~r_busy | w_frame_end;
  assign tx    = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_baud_cnt <= '0;
      r_bit_idx  <= 4'd0;
      r_data     <= 8'h00;
      r_tx       <= 1'b1;
    end else if (valid && ready) begin
      r_busy     <= 1'b1;
      r_baud_cnt <= '0;
      r_bit_idx  <= 4'd0;
      r_data     <= data;
      r_tx       <= 1'b0;
    end else if (w_frame_end) begin
      r_busy     <= 1'b0;
      r_baud_cnt <= '0;
      r_bit_idx  <= 4'd0;
      r_tx       <= 1'b1;
    end else if (r_busy) begin
      if (w_bit_end) begin
        r_baud_cnt <= '0;
        r_bit_idx  <= r_bit_idx + 4'd1;
        // Slot k+1 carries data bit k; slot 9 is the stop bit.
        if (r_bit_idx == C_LAST_DATA) begin
          r_tx <= 1'b1;
        end else begin
          r_tx <= r_data[r_bit_idx[2:0]];
        end
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/button_press_tx.sv
// ============================================================================
// Module   : button_press_tx
// Purpose  : Debounces the push-button and reports the press count over UART
//            as "HH\r\n" on every accepted press.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_press_tx
  import button_uart_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int BAUD            = 115200,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_n,
  output logic       uart_tx,
  output logic       busy,
  output logic [7:0] press_count
);

  localparam int               BAUD_DIV    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int               DB_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  C_DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       C_LAST_BYTE = 2'(MSG_BYTES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_stable;
  logic            r_stable_q;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_press_pulse;
  logic [7:0]      r_count;
  msg_state_t      r_state;
  logic [1:0]      r_byte_idx;
  logic [7:0]      r_snap;
  logic            r_pending;

  logic            w_sample;
  logic [7:0]      w_count_next;
  logic            w_msg_req;
  logic            w_last_done;
  logic            w_msg_start;
  logic [1:0]      w_next_idx;
  msg_state_t      w_state_next;
  logic            w_tx_valid;
  logic [7:0]      w_tx_data;
  logic            w_tx_ready;

  assign w_sample     = ~r_sync2;
  assign w_count_next = r_count + {7'd0, r_press_pulse};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_stable      <= 1'b0;
      r_stable_q    <= 1'b0;
      r_db_cnt      <= '0;
      r_press_pulse <= 1'b0;
      r_count       <= 8'h00;
    end else begin
      r_sync1       <= button_n;
      r_sync2       <= r_sync1;
      r_stable_q    <= r_stable;
      r_press_pulse <= r_stable & ~r_stable_q;
      r_count       <= w_count_next;
      if (w_sample == r_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == C_DB_LAST) begin
        r_stable <= w_sample;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // The serializer is busy throughout SEND, so ready there marks the end of a byte.
  assign w_msg_req   = r_press_pulse | r_pending;
  assign w_last_done = (r_byte_idx == C_LAST_BYTE) && w_tx_ready;
  assign w_msg_start = ((r_state == ST_IDLE) && w_msg_req) ||
                       ((r_state == ST_SEND) && w_last_done && w_msg_req);
  assign w_next_idx  = r_byte_idx + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_msg_req) w_state_next = ST_SEND;
      ST_SEND: if (w_last_done && !w_msg_req) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tx_valid = 1'b0;
    w_tx_data  = nibble_to_hex(w_count_next[7:4]);
    case (r_state)
      ST_IDLE: w_tx_valid = w_msg_req;
      ST_SEND: begin
        if (r_byte_idx == C_LAST_BYTE) begin
          w_tx_valid = w_msg_req;
        end else begin
          w_tx_valid = 1'b1;
          case (w_next_idx)
            2'd1:    w_tx_data = nibble_to_hex(r_snap[3:0]);
            2'd2:    w_tx_data = ASCII_CR;
            default: w_tx_data = ASCII_LF;
          endcase
        end
      end
      default: w_tx_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_idx <= 2'd0;
      r_snap     <= 8'h00;
      r_pending  <= 1'b0;
    end else if (w_msg_start) begin
      r_byte_idx <= 2'd0;
      r_snap     <= w_count_next;
      r_pending  <= 1'b0;
    end else if (r_state == ST_SEND) begin
      if (w_tx_ready) r_byte_idx <= w_next_idx;
      if (r_press_pulse) r_pending <= 1'b1;
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .data  (w_tx_data),
    .valid (w_tx_valid),
    .ready (w_tx_ready),
    .tx    (uart_tx)
  );

  assign busy        = (r_state == ST_SEND) || r_pending;
  assign press_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_button_press_tx.sv
// ============================================================================
// Module   : tb_button_press_tx
// Purpose  : Directed self-checking bench for button_press_tx (BAUD_DIV = 4,
//            DEBOUNCE_CYCLES = 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_press_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button_n = 1'b1;
  logic       uart_tx;
  logic       busy;
  logic [7:0] press_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_press_tx #(
    .CLK_HZ          (400),
    .BAUD            (100),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .button_n    (button_n),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .press_count (press_count)
  );

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  // Four frames, byte 0 in the low bits, each as {stop bit, data byte}.
  function automatic logic [35:0] exp_msg(input logic [7:0] c);
    return {1'b1, 8'h0A, 1'b1, 8'h0D, 1'b1, hex_char(c[3:0]), 1'b1, hex_char(c[7:4])};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    button_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Entered and left on a negedge; leaves at the first cycle after the stop bit.
  task automatic recv_byte(output logic [8:0] frame, output int start_cyc, output bit ok);
    int t = 0;
    frame = '0;
    start_cyc = 0;
    ok = 1'b1;
    while (uart_tx !== 1'b0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (uart_tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    start_cyc = cyc;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      frame[i] = uart_tx;
    end
    repeat (4) @(negedge clk);
    frame[8] = uart_tx;
    repeat (2) @(negedge clk);
  endtask

  task automatic recv_msg(output logic [35:0] frames, output int first_start,
                          output int last_start, output bit ok);
    logic [8:0] fr;
    int         st;
    bit         b_ok;
    frames = '0;
    first_start = 0;
    last_start = 0;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      recv_byte(fr, st, b_ok);
      if (!b_ok) begin
        ok = 1'b0;
        return;
      end
      frames[k*9 +: 9] = fr;
      if (k == 0) first_start = st;
      last_start = st;
    end
  endtask

  task automatic watch_line(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    button_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (press_count !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h want 00", press_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_press();
    logic [35:0] fr;
    int s0, s3, lat, lows;
    bit ok;
    do_reset();
    button_n = 1'b0;
    lat = 0;
    while (uart_tx !== 1'b0 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== 12) begin n_fail++; $display("FAIL press_latency: got %0d want 12", lat); end
    n_checks++;
    if (press_count !== 8'h01) begin n_fail++; $display("FAIL single_count: got %h want 01", press_count); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_hi: got %b want 1", busy); end
    recv_msg(fr, s0, s3, ok);
    n_checks++;
    if (!ok || fr !== exp_msg(8'h01)) begin
      n_fail++;
      $display("FAIL single_msg: got %h want %h (ok=%0d)", fr, exp_msg(8'h01), ok);
    end
    n_checks++;
    if (s3 - s0 !== 120) begin n_fail++; $display("FAIL single_gapless: got %0d want 120", s3 - s0); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
    // Release after a stable press must produce nothing.
    button_n = 1'b1;
    watch_line(60, lows);
    n_checks++;
    if (lows !== 0) begin n_fail++; $display("FAIL release_line: got %0d low cycles want 0", lows); end
    n_checks++;
    if (press_count !== 8'h01) begin n_fail++; $display("FAIL release_count: got %h want 01", press_count); end
  endtask

  task automatic test_bounce();
    logic [35:0] fr;
    int s0, s3, lows;
    bit ok;
    do_reset();
    button_n = 1'b0;
    repeat (7) @(negedge clk);
    button_n = 1'b1;
    watch_line(40, lows);
    n_checks++;
    if (lows !== 0) begin n_fail++; $display("FAIL bounce_line: got %0d low cycles want 0", lows); end
    n_checks++;
    if (press_count !== 8'h00) begin n_fail++; $display("FAIL bounce_count: got %h want 00", press_count); end
    button_n = 1'b0;
    repeat (8) @(negedge clk);
    button_n = 1'b1;
    recv_msg(fr, s0, s3, ok);
    n_checks++;
    if (!ok || fr !== exp_msg(8'h01)) begin
      n_fail++;
      $display("FAIL bounce8_msg: got %h want %h (ok=%0d)", fr, exp_msg(8'h01), ok);
    end
    n_checks++;
    if (press_count !== 8'h01) begin n_fail++; $display("FAIL bounce8_count: got %h want 01", press_count); end
  endtask

  task automatic test_back_to_back();
    logic [35:0] f1, f2;
    int s1, l1, s2, l2, lows;
    bit ok1, ok2;
    do_reset();
    fork
      begin
        recv_msg(f1, s1, l1, ok1);
        recv_msg(f2, s2, l2, ok2);
      end
      begin
        for (int p = 0; p < 3; p++) begin
          button_n = 1'b0;
          repeat (20) @(negedge clk);
          button_n = 1'b1;
          repeat (20) @(negedge clk);
        end
      end
    join
    n_checks++;
    if (!ok1 || f1 !== exp_msg(8'h01)) begin
      n_fail++;
      $display("FAIL b2b_msg1: got %h want %h (ok=%0d)", f1, exp_msg(8'h01), ok1);
    end
    n_checks++;
    if (!ok2 || f2 !== exp_msg(8'h03)) begin
      n_fail++;
      $display("FAIL b2b_msg2: got %h want %h (ok=%0d)", f2, exp_msg(8'h03), ok2);
    end
    n_checks++;
    if (s2 - s1 !== 160) begin n_fail++; $display("FAIL b2b_gap: got %0d want 160", s2 - s1); end
    n_checks++;
    if (press_count !== 8'h03) begin n_fail++; $display("FAIL b2b_count: got %h want 03", press_count); end
    watch_line(200, lows);
    n_checks++;
    if (lows !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_third: got %0d low cycles busy=%b want 0/0", lows, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int t, lows;
    do_reset();
    button_n = 1'b0;
    t = 0;
    while (uart_tx !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    button_n = 1'b1;
    repeat (48) @(negedge clk);
    // Data bit 3 of '1' (0x31) is 0, so the line is low here.
    n_checks++;
    if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL midframe_bit3: got %b want 0", uart_tx); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (uart_tx !== 1'b1 || busy !== 1'b0 || press_count !== 8'h00) begin
      n_fail++;
      $display("FAIL midframe_reset: got tx=%b busy=%b cnt=%h want 1/0/00", uart_tx, busy, press_count);
    end
    rst = 1'b0;
    watch_line(100, lows);
    n_checks++;
    if (lows !== 0 || press_count !== 8'h00) begin
      n_fail++;
      $display("FAIL midframe_quiet: got %0d low cycles cnt=%h want 0/00", lows, press_count);
    end
  endtask

  task automatic test_wrap();
    logic [35:0] fr;
    int s0, s3;
    bit ok;
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      button_n = 1'b0;
      recv_msg(fr, s0, s3, ok);
      button_n = 1'b1;
      repeat (20) @(negedge clk);
      n_checks++;
      if (!ok || fr !== exp_msg(8'(i))) begin
        n_fail++;
        $display("FAIL wrap_msg%0d: got %h want %h (ok=%0d)", i, fr, exp_msg(8'(i)), ok);
      end
    end
    n_checks++;
    if (press_count !== 8'h00) begin n_fail++; $display("FAIL wrap_count: got %h want 00", press_count); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_back_to_back();
    test_reset_mid_frame();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
